// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared widths, FSM encoding and ALU select codes for the ALU sequencer
package alu_seq_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int SEL_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_e;

    // ALU operation select codes, shared with the ALU and the benches
    localparam logic [2:0] SEL_ADD  = 3'd0;
    localparam logic [2:0] SEL_SUB  = 3'd1;
    localparam logic [2:0] SEL_AND  = 3'd2;
    localparam logic [2:0] SEL_OR   = 3'd3;
    localparam logic [2:0] SEL_XOR  = 3'd4;
    localparam logic [2:0] SEL_NAND = 3'd5;
    localparam logic [2:0] SEL_SHL  = 3'd6;
    localparam logic [2:0] SEL_SHR  = 3'd7;

endpackage

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/settle/capture/hold front end for the combinational ALU
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [CNT_W-1:0] rsp_count
);

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_SETTLE = 2'(ST_SETTLE);
    localparam logic [1:0] S_HOLD   = 2'(ST_HOLD);

    // SETTLE is bounded to 1..15, so four bits hold the countdown
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    logic [1:0]       state_q,     state_d;
    logic [3:0]       cnt_q,       cnt_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    logic [SEL_W-1:0] alu_sel_q,   alu_sel_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0] rsp_count_q, rsp_count_d;
    logic [WIDTH-1:0] last_q,      last_d;

    // Next-state logic: accept in IDLE, count down in SETTLE, wait for the consumer in HOLD
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_count_d = rsp_count_q;
        last_d      = last_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    alu_a_d   = req_chain ? last_q : req_a;
                    alu_b_d   = req_b;
                    alu_sel_d = req_sel;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = alu_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    // the chain operand is the last result the consumer actually took
                    last_d      = rsp_data_q;
                    rsp_count_d = rsp_count_q + CNT_W'(1);
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_count_q <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_count_q <= rsp_count_d;
            last_q      <= last_d;
        end
    end

    // Ready is held low while reset is asserted so nothing is taken during reset
    assign req_ready = rst_n && (state_q == S_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance with SETTLE=1
    logic       rst_n, req_valid, req_ready, req_chain, rsp_valid, rsp_ready;
    logic [3:0] req_a, req_b, alu_a, alu_b, alu_out, rsp_data;
    logic [2:0] req_sel, alu_sel;
    logic [7:0] rsp_count;

    // instance with SETTLE=3
    logic       rst3_n, req3_valid, req3_ready, req3_chain, rsp3_valid, rsp3_ready;
    logic [3:0] req3_a, req3_b, alu3_a, alu3_b, alu3_out, rsp3_data;
    logic [2:0] req3_sel, alu3_sel;
    logic [7:0] rsp3_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] m_last;
    int         m_count;

    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        int r;
        case (s)
            SEL_ADD:  r = int'(a) + int'(b);
            SEL_SUB:  r = int'(a) - int'(b);
            SEL_AND:  r = int'(a & b);
            SEL_OR:   r = int'(a | b);
            SEL_XOR:  r = int'(a ^ b);
            SEL_NAND: r = int'(~(a & b));
            SEL_SHL:  r = int'(a) * 2;
            default:  r = int'(a) / 2;
        endcase
        return 4'(r);
    endfunction

    assign alu_out  = alu_ref(alu_a, alu_b, alu_sel);
    assign alu3_out = alu_ref(alu3_a, alu3_b, alu3_sel);

    alu_op_sequencer #(.WIDTH(4), .SEL_W(3), .SETTLE(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_chain(req_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_count(rsp_count)
    );

    alu_op_sequencer #(.WIDTH(4), .SEL_W(3), .SETTLE(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .req_valid(req3_valid), .req_ready(req3_ready),
        .req_a(req3_a), .req_b(req3_b), .req_sel(req3_sel), .req_chain(req3_chain),
        .alu_a(alu3_a), .alu_b(alu3_b), .alu_sel(alu3_sel), .alu_out(alu3_out),
        .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready), .rsp_data(rsp3_data), .rsp_count(rsp3_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                         input logic chain, input int hold, input logic [3:0] exp);
        logic [3:0] ea;
        int n;
        ea = chain ? m_last : a;
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        chk("accept_ready", 32'(req_ready), 1);
        req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel; req_chain = chain;
        rsp_ready = (hold == 0);
        step();
        req_valid = 1'b0;
        req_a = 4'($urandom); req_b = 4'($urandom); req_sel = 3'($urandom); req_chain = 1'($urandom);
        chk("alu_a", 32'(alu_a), 32'(ea));
        chk("alu_b", 32'(alu_b), 32'(b));
        chk("alu_sel", 32'(alu_sel), 32'(sel));
        chk("busy_ready", 32'(req_ready), 0);
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        chk("latency", 32'(n), 1);
        chk("rsp_data", 32'(rsp_data), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            step();
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(exp));
            chk("hold_ready", 32'(req_ready), 0);
            chk("hold_alu_a", 32'(alu_a), 32'(ea));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        m_last = exp;
        m_count++;
        chk("done_valid", 32'(rsp_valid), 0);
        chk("done_ready", 32'(req_ready), 1);
        chk("rsp_count", 32'(rsp_count), 32'(m_count % 256));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_last = 4'd0;
        m_count = 0;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic       chain;
        int         hold;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [3:0] ra, rb, ea;
        logic [2:0] rs;
        logic       rc;
        int         n;

        vecs[0] = '{4'd1,  4'd1,  SEL_ADD,  1'b0, 5, 4'h2};
        vecs[1] = '{4'd5,  4'd6,  SEL_NAND, 1'b0, 0, 4'hB};
        vecs[2] = '{4'd0,  4'd3,  SEL_ADD,  1'b1, 1, 4'hE};
        vecs[3] = '{4'd3,  4'd5,  SEL_SUB,  1'b0, 0, 4'hE};
        vecs[4] = '{4'hF,  4'd1,  SEL_ADD,  1'b0, 2, 4'h0};
        vecs[5] = '{4'hC,  4'hA,  SEL_AND,  1'b0, 0, 4'h8};
        vecs[6] = '{4'hC,  4'hA,  SEL_OR,   1'b0, 0, 4'hE};
        vecs[7] = '{4'hC,  4'hA,  SEL_XOR,  1'b0, 3, 4'h6};
        vecs[8] = '{4'd9,  4'd0,  SEL_SHL,  1'b0, 0, 4'h2};
        vecs[9] = '{4'd0,  4'd0,  SEL_SHR,  1'b1, 0, 4'h1};

        req_valid = 0; req_a = 0; req_b = 0; req_sel = 0; req_chain = 0; rsp_ready = 0;
        req3_valid = 0; req3_a = 0; req3_b = 0; req3_sel = 0; req3_chain = 0; rsp3_ready = 0;
        rst3_n = 1'b0;

        // reset and idle
        rst_n = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_count", 32'(rsp_count), 0);
        chk("rst_alu", {20'd0, alu_a, alu_b, alu_sel, 1'b0}, 0);
        rst_n = 1'b1;
        m_last = 4'd0;
        m_count = 0;
        step();
        chk("idle_ready", 32'(req_ready), 1);
        chk("idle_valid", 32'(rsp_valid), 0);
        chk("idle_count", 32'(rsp_count), 0);

        // directed vectors
        foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].chain, vecs[i].hold, vecs[i].exp);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rs = 3'($urandom); rc = 1'($urandom);
            ea = rc ? m_last : ra;
            do_op(ra, rb, rs, rc, $urandom_range(0, 3), alu_ref(ea, rb, rs));
        end

        // chain after reset uses zero, then run the counter through its wrap
        reset_dut();
        do_op(4'd7, 4'd2, SEL_ADD, 1'b1, 0, 4'd2);
        for (int i = 0; i < 255; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rs = 3'($urandom); rc = 1'($urandom);
            ea = rc ? m_last : ra;
            do_op(ra, rb, rs, rc, 0, alu_ref(ea, rb, rs));
        end
        chk("wrap_zero", 32'(rsp_count), 0);
        do_op(4'd1, 4'd2, SEL_OR, 1'b0, 0, 4'd3);
        chk("wrap_one", 32'(rsp_count), 1);

        // SETTLE=3 instance: latency, then reset in the middle of SETTLE
        step();
        rst3_n = 1'b1;
        step();
        chk("s3_ready", 32'(req3_ready), 1);
        req3_valid = 1'b1; req3_a = 4'd2; req3_b = 4'd3; req3_sel = SEL_ADD;
        step();
        req3_valid = 1'b0; req3_a = 4'd9;
        chk("s3_alu_a", 32'(alu3_a), 2);
        n = 0;
        while (!rsp3_valid && n < 20) begin step(); n++; end
        chk("s3_latency", 32'(n), 3);
        chk("s3_data", 32'(rsp3_data), 5);
        rsp3_ready = 1'b1;
        step();
        rsp3_ready = 1'b0;
        chk("s3_count", 32'(rsp3_count), 1);

        req3_valid = 1'b1; req3_a = 4'd7; req3_b = 4'd7; req3_sel = SEL_XOR;
        step();
        req3_valid = 1'b0;
        step();
        rst3_n = 1'b0;
        step();
        rst3_n = 1'b1;
        rsp3_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("midrst_valid", 32'(rsp3_valid), 0);
            step();
        end
        rsp3_ready = 1'b0;
        chk("midrst_count", 32'(rsp3_count), 0);
        chk("midrst_alu", {20'd0, alu3_a, alu3_b, alu3_sel, 1'b0}, 0);

        req3_valid = 1'b1; req3_a = 4'd9; req3_b = 4'd4; req3_sel = SEL_ADD; req3_chain = 1'b1;
        step();
        req3_valid = 1'b0;
        chk("s3_chain_a", 32'(alu3_a), 0);
        n = 0;
        while (!rsp3_valid && n < 20) begin step(); n++; end
        chk("s3_chain_data", 32'(rsp3_data), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Clocked initiator that drives the combinational 4-bit ALU: it accepts one operation request (A, B, SEL) over a valid/ready handshake, presents the operands on the ALU inputs, waits a fixed settle time, and captures OUT. It then holds the result on a valid/ready response port until consumed. It replaces hand-sequenced stimulus with a hardware front end, and supports chaining, where the previous result becomes the next A.

## Interface
- WIDTH, 4: operand/result width (matches the ALU).
- SEL_W, 3: ALU select width.
- SETTLE, 1: cycles the operands are held on the ALU before OUT is sampled; legal range 1..15.
- CNT_W, 8: completed-operation counter width.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- req_sel  in  SEL_W  ALU operation select
- req_chain  in  1  1: use last consumed result as A, ignore req_a
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_sel  out  SEL_W  to ALU SEL
- alu_out  in  WIDTH  from ALU OUT
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  WIDTH  captured ALU result
- rsp_count  out  CNT_W  number of consumed responses

## Operation
- The FSM has 3 states: IDLE, SETTLE, HOLD.
- IDLE
  - req_ready=1.
  - On req_valid, load alu_a (req_chain ? last_result : req_a), alu_b=req_b, alu_sel=req_sel.
  - Load settle counter=SETTLE-1; go to SETTLE.
- SETTLE
  - req_ready=0; operands frozen.
  - Counter decrements each cycle.
  - When the counter is 0: rsp_data<=alu_out, rsp_valid<=1, go to HOLD.
- HOLD
  - req_ready=0; rsp_data and rsp_valid stable.
  - On rsp_ready: last_result<=rsp_data, rsp_count<=rsp_count+1 (wraps 2^CNT_W-1 -> 0), rsp_valid<=0, go to IDLE.
- alu_a/alu_b/alu_sel keep their last values in IDLE and HOLD. They change only on an accepted request.
- last_result updates only on response handshake, never on capture. A chain request after reset uses 0.
- req_* are ignored while req_ready=0. There is no buffering and no overflow path.
- All arithmetic is in the ALU; this block does no arithmetic except the counters.

## Timing
- Reset (rst_n=0 at a clock edge):
  - State=IDLE.
  - alu_a=0, alu_b=0, alu_sel=0, rsp_valid=0, rsp_data=0, rsp_count=0, last_result=0.
  - req_ready=0 while rst_n=0; req_ready=1 from the first edge with rst_n=1.
- Request accepted at edge t0 (req_valid & req_ready):
  - alu_* are valid after t0.
  - alu_out is sampled at edge t0+SETTLE.
  - rsp_valid is high after t0+SETTLE.
- Response consumed at edge t1 (rsp_valid & rsp_ready): req_ready is high after t1. Next accept is no earlier than t1+1.
- Throughput: one operation per SETTLE+2 cycles at best.
- rsp_ready high before rsp_valid has no effect. Handshake occurs on the first edge where both are high.
- Reset mid-operation (SETTLE or HOLD):
  - The in-flight operation is discarded; no response is produced.
  - The counter and last_result are cleared.
- The ALU is purely combinational; SETTLE=1 is sufficient for the current ALU.

## Structure
- Package alu_seq_pkg holds:
  - WIDTH/SEL_W defaults;
  - state enum (IDLE=0, SETTLE=1, HOLD=2);
  - named SEL constants shared with the ALU and benches.
- No sub-module is required; the settle countdown lives inline.
- The ALU is instantiated beside this block at the level above, not inside it.

## Test plan
- Reset then idle:
  - rst_n=0 for 2 cycles -> all outputs 0 during reset.
  - After release, req_ready=1, rsp_valid=0, rsp_count=0.
- Single op, SETTLE=1:
  - A=1, B=1, SEL=0 accepted at t0 -> alu_a=1/alu_b=1/alu_sel=0 after t0.
  - rsp_valid=1 with rsp_data = ALU OUT for (1,1,SEL 0) after t0+1; req_ready=0 until consumed.
- Backpressure:
  - Same op with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable and req_ready=0 throughout.
  - A request driven during that window is ignored.
- Chaining:
  - Op A=5, B=6, SEL=5 consumed -> next request with req_chain=1, req_a=0 drives alu_a = previous rsp_data.
  - After reset, a chain request drives alu_a=0.
- Mid-op reset:
  - Assert rst_n=0 during SETTLE (SETTLE=3) -> no rsp_valid, rsp_count stays 0, alu_*=0.
- Counter wrap:
  - Complete 256 ops (CNT_W=8) -> rsp_count reads 0 after the 256th handshake and 1 after the next.
